inst_fetch: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Takes the current PC and issues one word read per instruction on the instruction memory bus using a valid/ready request and a response-valid return. Holds the returned word in a one-entry instruction register and presents it to the decode/control path. Supports flush on redirect (branch, jump, exception) and a response watchdog.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch_watchdog.sv | 44 ++++
 rtl/inst_fetch.sv | 151 +++++++++++++++
 tb/tb_inst_fetch.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: fetch state encoding,
// the instruction used when no real word is available, and the default
// response timeout.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_FULL = 2'd3
    } fetch_state_t;

    // All-zero word (sll $0,$0,0) used for faulted or timed-out fetches.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int FETCH_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
//
// Handshake: the request phase is a valid/ready pair. mem_req is the valid;
// once raised, mem_req and mem_addr stay constant until a cycle in which
// mem_ready is also high, and that cycle is the transfer. The response phase
// has no back-pressure: mem_rvalid marks the single cycle in which mem_rdata
// and mem_err are meaningful, and it arrives at least one cycle after the
// request transfer.
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_addr,
        input  mem_ready, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ready, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/inst_fetch_watchdog.sv
// Response watchdog for the fetch stage. Counts cycles while count_en is
// high and flags expiry in the cycle in which the count reaches TIMEOUT_CYC.
// The counter saturates so it never wraps back to a small value.
module fetch_watchdog
    import inst_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = FETCH_TIMEOUT_DEFAULT
) (
    input  logic clk_cpu,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up to the saturation value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is the cycle whose count step lands on TIMEOUT_CYC.
    assign expired = count_en && !clear && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage. Issues one bus read per instruction for the
// current PC, holds the returned word in a one-entry instruction register
// and supports flush on redirect plus a response watchdog.
//
// Build option: define FETCH_MISALIGN_EXCP_EN to turn a misaligned pc into
// an immediate fetch exception instead of silently aligning it.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = FETCH_TIMEOUT_DEFAULT
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              flush,
    inst_fetch_if.master      bus,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ack,
    output logic              fetch_excp,
    output logic              busy,
    output fetch_state_t      dbg_state
);
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INST);

    fetch_state_t      state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] inst_q;
    logic              inst_valid_q;
    logic              fetch_excp_q;
    logic              drop_q;

    logic wd_expired;
    logic start_fetch;
    logic drop_now;
    logic in_wait;

    assign in_wait = (state_q == FS_WAIT);

    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .clear    (!in_wait),
        .count_en (in_wait),
        .expired  (wd_expired)
    );

    // A new fetch starts from IDLE, or from FULL when the held word is taken
    // in the same cycle. Flush always blocks it.
    assign start_fetch = fetch_en && !flush &&
                         ((state_q == FS_IDLE) ||
                          ((state_q == FS_FULL) && inst_ack));

    // A flush arriving together with the response still discards it.
    assign drop_now = drop_q || flush;

`ifndef FETCH_MISALIGN_EXCP_EN
    // The low pc bits are ignored when misaligned fetches are simply aligned.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];
`endif

    // Fetch FSM with registered bus and instruction outputs.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q      <= FS_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_q       <= NOP_WORD;
            inst_valid_q <= 1'b0;
            fetch_excp_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    inst_valid_q <= 1'b0;
                end
                FS_REQ: begin
                    // Request stays up with a stable address even on flush;
                    // the flush only marks the eventual response for discard.
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (bus.mem_rvalid || wd_expired) begin
                        if (drop_now) begin
                            drop_q  <= 1'b0;
                            state_q <= FS_IDLE;
                        end else begin
                            inst_q       <= bus.mem_rvalid ? bus.mem_rdata : NOP_WORD;
                            fetch_excp_q <= bus.mem_rvalid ? bus.mem_err : 1'b1;
                            inst_valid_q <= 1'b1;
                            state_q      <= FS_FULL;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
                FS_FULL: begin
                    if (flush || inst_ack) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= FS_IDLE;
                    end
                end
                default: begin
                    state_q <= FS_IDLE;
                end
            endcase

            // Starting a fetch overrides the FULL->IDLE step taken above.
            if (start_fetch) begin
`ifdef FETCH_MISALIGN_EXCP_EN
                if (pc[1:0] != 2'b00) begin
                    inst_q       <= NOP_WORD;
                    fetch_excp_q <= 1'b1;
                    inst_valid_q <= 1'b1;
                    state_q      <= FS_FULL;
                end else begin
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= {pc[ADDR_W-1:2], 2'b00};
                    state_q    <= FS_REQ;
                end
`else
                mem_req_q  <= 1'b1;
                mem_addr_q <= {pc[ADDR_W-1:2], 2'b00};
                state_q    <= FS_REQ;
`endif
            end
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign inst         = inst_q;
    assign inst_valid   = inst_valid_q;
    assign fetch_excp   = fetch_excp_q;
    assign busy         = (state_q == FS_REQ) || (state_q == FS_WAIT);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized transaction
// loop checked against a transaction-level scoreboard.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 255;

    logic              clk_cpu = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              flush;
    logic [DATA_W-1:0] inst;
    logic              inst_valid;
    logic              inst_ack;
    logic              fetch_excp;
    logic              busy;
    fetch_state_t      dbg_state;

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected {fetch_excp, inst} results.
    logic [DATA_W:0] exp_q[$];

    inst_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_fetch #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .flush      (flush),
        .bus        (bus),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ack   (inst_ack),
        .fetch_excp (fetch_excp),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock and reset block.
    always #5 clk_cpu = ~clk_cpu;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk_cpu);
    endtask

    task automatic idle_inputs();
        fetch_en       = 1'b0;
        flush          = 1'b0;
        inst_ack       = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_err    = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic start_drv(input logic [ADDR_W-1:0] a);
        pc = a;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic accept_drv(input int delay);
        repeat (delay) tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
    endtask

    task automatic respond_drv(input int delay, input logic [DATA_W-1:0] d, input logic e);
        repeat (delay) tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = d;
        bus.mem_err    = e;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_err    = 1'b0;
    endtask

    task automatic ack_drv();
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        pc = '0;
        repeat (3) tick();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: mem_req=%b mem_addr=%h expected 0 00000000", bus.mem_req, bus.mem_addr);
        end
        checks++;
        if (inst !== 32'h0 || inst_valid !== 1'b0 || fetch_excp !== 1'b0) begin
            errors++;
            $display("FAIL reset_inst: inst=%h valid=%b excp=%b expected 00000000 0 0", inst, inst_valid, fetch_excp);
        end
        checks++;
        if (busy !== 1'b0 || dbg_state !== FS_IDLE) begin
            errors++;
            $display("FAIL reset_state: busy=%b state=%0d expected 0 %0d", busy, dbg_state, FS_IDLE);
        end
        // Reset while a response is outstanding.
        reset = 1'b0;
        start_drv(32'h0000_0100);
        accept_drv(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.mem_req !== 1'b0 || dbg_state !== FS_IDLE) begin
            errors++;
            $display("FAIL reset_midtxn: busy=%b mem_req=%b state=%0d expected 0 0 %0d", busy, bus.mem_req, dbg_state, FS_IDLE);
        end
        respond_drv(0, 32'hCAFE_F00D, 1'b0);
        checks++;
        if (inst_valid !== 1'b0 || dbg_state !== FS_IDLE) begin
            errors++;
            $display("FAIL reset_stray_rsp: valid=%b state=%0d expected 0 %0d", inst_valid, dbg_state, FS_IDLE);
        end
    endtask

    task automatic test_basic();
        start_drv(32'h0040_0000);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0040_0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_req: mem_req=%b mem_addr=%h busy=%b expected 1 00400000 1", bus.mem_req, bus.mem_addr, busy);
        end
        accept_drv(0);
        checks++;
        if (bus.mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait: mem_req=%b valid=%b expected 0 0", bus.mem_req, inst_valid);
        end
        respond_drv(0, 32'h8C02_0004, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h8C02_0004 || fetch_excp !== 1'b0) begin
            errors++;
            $display("FAIL basic_load: valid=%b inst=%h excp=%b expected 1 8c020004 0", inst_valid, inst, fetch_excp);
        end
        ack_drv();
        checks++;
        if (inst_valid !== 1'b0 || dbg_state !== FS_IDLE) begin
            errors++;
            $display("FAIL basic_ack: valid=%b state=%0d expected 0 %0d", inst_valid, dbg_state, FS_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d1, d2;
        d1 = $urandom;
        d2 = $urandom;
        start_drv(32'h0040_0000);
        accept_drv(0);
        respond_drv(0, d1, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== d1) begin
            errors++;
            $display("FAIL b2b_first: valid=%b inst=%h expected 1 %h", inst_valid, inst, d1);
        end
        pc = 32'h0040_0004;
        inst_ack = 1'b1;
        fetch_en = 1'b1;
        tick();
        inst_ack = 1'b0;
        fetch_en = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0040_0004 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_req: mem_req=%b mem_addr=%h valid=%b expected 1 00400004 0", bus.mem_req, bus.mem_addr, inst_valid);
        end
        accept_drv(0);
        respond_drv(1, d2, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== d2 || fetch_excp !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b inst=%h excp=%b expected 1 %h 0", inst_valid, inst, fetch_excp, d2);
        end
        ack_drv();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d;
        d = $urandom;
        start_drv(32'h0040_0020);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0040_0020 || busy !== 1'b1 || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: mem_req=%b mem_addr=%h busy=%b valid=%b expected 1 00400020 1 0",
                         i, bus.mem_req, bus.mem_addr, busy, inst_valid);
            end
            tick();
        end
        accept_drv(0);
        respond_drv(2, d, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== d) begin
            errors++;
            $display("FAIL backpressure_load: valid=%b inst=%h expected 1 %h", inst_valid, inst, d);
        end
        ack_drv();
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] d;
        d = $urandom;
        // Flush while waiting for the response.
        start_drv(32'h0040_0010);
        accept_drv(0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_hold: busy=%b valid=%b expected 1 0", busy, inst_valid);
        end
        respond_drv(0, 32'h1234_5678, 1'b0);
        checks++;
        if (inst_valid !== 1'b0 || dbg_state !== FS_IDLE) begin
            errors++;
            $display("FAIL flush_wait_drop: valid=%b state=%0d expected 0 %0d", inst_valid, dbg_state, FS_IDLE);
        end
        start_drv(32'h0040_0014);
        accept_drv(0);
        respond_drv(0, d, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== d) begin
            errors++;
            $display("FAIL flush_recover: valid=%b inst=%h expected 1 %h", inst_valid, inst, d);
        end
        // Flush, fetch_en and ack together in FULL: flush wins.
        pc = 32'h0040_0018;
        flush = 1'b1;
        fetch_en = 1'b1;
        inst_ack = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.mem_req !== 1'b0 || inst_valid !== 1'b0 || dbg_state !== FS_IDLE) begin
            errors++;
            $display("FAIL flush_priority: mem_req=%b valid=%b state=%0d expected 0 0 %0d", bus.mem_req, inst_valid, dbg_state, FS_IDLE);
        end
        // Flush during the request phase: request must stay up.
        start_drv(32'h0040_001C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0040_001C) begin
            errors++;
            $display("FAIL flush_req_hold: mem_req=%b mem_addr=%h expected 1 0040001c", bus.mem_req, bus.mem_addr);
        end
        accept_drv(0);
        respond_drv(0, d, 1'b0);
        checks++;
        if (inst_valid !== 1'b0 || dbg_state !== FS_IDLE) begin
            errors++;
            $display("FAIL flush_req_drop: valid=%b state=%0d expected 0 %0d", inst_valid, dbg_state, FS_IDLE);
        end
    endtask

    task automatic test_bus_error();
        logic [DATA_W-1:0] d;
        d = $urandom;
        start_drv(32'h0040_0040);
        accept_drv(1);
        respond_drv(0, d, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || fetch_excp !== 1'b1 || inst !== d) begin
            errors++;
            $display("FAIL bus_error: valid=%b excp=%b inst=%h expected 1 1 %h", inst_valid, fetch_excp, inst, d);
        end
        ack_drv();
    endtask

    task automatic test_timeout();
        int n;
        start_drv(32'h0040_0080);
        accept_drv(0);
        n = 0;
        while (inst_valid !== 1'b1 && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (n !== TIMEOUT_CYC) begin
            errors++;
            $display("FAIL timeout_cycles: waited=%0d expected %0d", n, TIMEOUT_CYC);
        end
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0 || fetch_excp !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: valid=%b inst=%h excp=%b expected 1 00000000 1", inst_valid, inst, fetch_excp);
        end
        // Late response while holding: must not disturb the held word.
        respond_drv(0, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0 || fetch_excp !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stray: valid=%b inst=%h excp=%b expected 1 00000000 1", inst_valid, inst, fetch_excp);
        end
        ack_drv();
    endtask

    task automatic test_misalign();
        logic [DATA_W-1:0] d;
        d = $urandom;
        start_drv(32'h0040_0002);
`ifdef FETCH_MISALIGN_EXCP_EN
        checks++;
        if (bus.mem_req !== 1'b0 || inst_valid !== 1'b1 || fetch_excp !== 1'b1 || inst !== 32'h0) begin
            errors++;
            $display("FAIL misalign_excp: mem_req=%b valid=%b excp=%b inst=%h expected 0 1 1 00000000",
                     bus.mem_req, inst_valid, fetch_excp, inst);
        end
        ack_drv();
`else
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0040_0000) begin
            errors++;
            $display("FAIL misalign_align: mem_req=%b mem_addr=%h expected 1 00400000", bus.mem_req, bus.mem_addr);
        end
        accept_drv(0);
        respond_drv(0, d, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || inst !== d || fetch_excp !== 1'b0) begin
            errors++;
            $display("FAIL misalign_load: valid=%b inst=%h excp=%b expected 1 %h 0", inst_valid, inst, fetch_excp, d);
        end
        ack_drv();
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            logic [DATA_W:0]   exp_item;
            logic              e;
            int                fm, d1, d2, ad;
            a = $urandom;
`ifdef FETCH_MISALIGN_EXCP_EN
            a = a & 32'hFFFF_FFFC;
`endif
            d  = $urandom;
            e  = ($urandom_range(0, 3) == 0);
            fm = $urandom_range(0, 3);   // 0,1: no flush; 2: in REQ; 3: in WAIT
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            start_drv(a);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== (a - (a % 4))) begin
                errors++;
                $display("FAIL rand_req[%0d]: mem_req=%b mem_addr=%h expected 1 %h", it, bus.mem_req, bus.mem_addr, a - (a % 4));
            end
            for (int k = 0; k <= d1; k++) begin
                bus.mem_ready = (k == d1);
                flush = (fm == 2) && (k == 0);
                tick();
            end
            bus.mem_ready = 1'b0;
            flush = 1'b0;
            for (int k = 0; k <= d2; k++) begin
                bus.mem_rvalid = (k == d2);
                bus.mem_rdata  = d;
                bus.mem_err    = e;
                flush = (fm == 3) && (k == 0);
                tick();
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_err    = 1'b0;
            flush = 1'b0;
            if (fm < 2) exp_q.push_back({e, d});
            if (exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                checks++;
                if (inst_valid !== 1'b1 || {fetch_excp, inst} !== exp_item) begin
                    errors++;
                    $display("FAIL rand_load[%0d]: valid=%b excp=%b inst=%h expected 1 %b %h",
                             it, inst_valid, fetch_excp, inst, exp_item[DATA_W], exp_item[DATA_W-1:0]);
                end
                ad = $urandom_range(0, 2);
                repeat (ad) tick();
                if ($urandom_range(0, 4) == 0) flush = 1'b1;
                else inst_ack = 1'b1;
                tick();
                flush = 1'b0;
                inst_ack = 1'b0;
                checks++;
                if (inst_valid !== 1'b0 || dbg_state !== FS_IDLE) begin
                    errors++;
                    $display("FAIL rand_release[%0d]: valid=%b state=%0d expected 0 %0d", it, inst_valid, dbg_state, FS_IDLE);
                end
            end else begin
                checks++;
                if (inst_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_drop[%0d]: valid=%b busy=%b expected 0 0", it, inst_valid, busy);
                end
            end
        end
    endtask

    // Test sequence and final report.
    initial begin
        reset = 1'b1;
        pc = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_bus_error();
        test_timeout();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
